// File: rtl/path_tracer_pkg.sv
// Shared constants for the path tracer: direction codes, cost encoding,
// error codes and direction-to-offset helpers.
package path_tracer_pkg;

    localparam int COST_W = 12;
    localparam logic [COST_W-1:0] COST_INF = 12'hFFF;

    localparam logic [2:0] DIR_N  = 3'd0;
    localparam logic [2:0] DIR_NE = 3'd1;
    localparam logic [2:0] DIR_E  = 3'd2;
    localparam logic [2:0] DIR_SE = 3'd3;
    localparam logic [2:0] DIR_S  = 3'd4;
    localparam logic [2:0] DIR_SW = 3'd5;
    localparam logic [2:0] DIR_W  = 3'd6;
    localparam logic [2:0] DIR_NW = 3'd7;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_UNREACH = 2'd1;
    localparam logic [1:0] ERR_LOOP    = 2'd2;
    localparam logic [1:0] ERR_BOUNDS  = 2'd3;

    // x step (-1, 0, +1) implied by a direction code
    function automatic logic signed [1:0] dirDx(input logic [2:0] dir);
        logic signed [1:0] d;
        d = 2'sd0;
        if (dir == DIR_NE || dir == DIR_E || dir == DIR_SE) d = 2'sd1;
        if (dir == DIR_SW || dir == DIR_W || dir == DIR_NW) d = -2'sd1;
        return d;
    endfunction

    // y step (-1, 0, +1) implied by a direction code; north is y-1
    function automatic logic signed [1:0] dirDy(input logic [2:0] dir);
        logic signed [1:0] d;
        d = 2'sd0;
        if (dir == DIR_SE || dir == DIR_S || dir == DIR_SW) d = 2'sd1;
        if (dir == DIR_N  || dir == DIR_NE || dir == DIR_NW) d = -2'sd1;
        return d;
    endfunction

endpackage

// File: rtl/path_tracer_dir_offset.sv
// Combinational neighbour lookup: moves (x, y) one node along dir and flags
// when the result falls off the grid.
module dir_offset
    import path_tracer_pkg::*;
#(
    parameter int GW = 16,
    parameter int GH = 16,
    parameter int XW = 4,
    parameter int YW = 4
) (
    input  logic [XW-1:0] i_x,
    input  logic [YW-1:0] i_y,
    input  logic [2:0]    i_dir,
    output logic [XW-1:0] o_nx,
    output logic [YW-1:0] o_ny,
    output logic          o_oob
);

    logic signed [1:0]  w_dxRaw;
    logic signed [1:0]  w_dyRaw;
    logic signed [XW:0] w_dx;
    logic signed [YW:0] w_dy;
    logic signed [XW:0] w_sx;
    logic signed [YW:0] w_sy;

    assign w_dxRaw = dirDx(i_dir);
    assign w_dyRaw = dirDy(i_dir);
    assign w_dx    = {{(XW-1){w_dxRaw[1]}}, w_dxRaw};
    assign w_dy    = {{(YW-1){w_dyRaw[1]}}, w_dyRaw};

    // One extra signed bit lets a step below zero show up as negative; a step
    // past the top of a power-of-two grid wraps negative and is caught too.
    assign w_sx = $signed({1'b0, i_x}) + w_dx;
    assign w_sy = $signed({1'b0, i_y}) + w_dy;

    assign o_nx  = w_sx[XW-1:0];
    assign o_ny  = w_sy[YW-1:0];
    assign o_oob = (w_sx < 0) || (int'(w_sx) >= GW) ||
                   (w_sy < 0) || (int'(w_sy) >= GH);

endmodule

// File: rtl/path_tracer.sv
// Walks a precomputed cost/direction grid backwards from a goal node,
// emitting each visited node over a valid/ready handshake until it reaches a
// zero-cost source, an unreachable node, the grid edge or the step limit.
module path_tracer
    import path_tracer_pkg::*;
#(
    parameter int GW        = 16,
    parameter int GH        = 16,
    parameter int XW        = 4,
    parameter int YW        = 4,
    parameter int MAX_STEPS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [XW-1:0]     goal_x,
    input  logic [YW-1:0]     goal_y,
    output logic [XW-1:0]     rd_x,
    output logic [YW-1:0]     rd_y,
    input  logic [COST_W-1:0] rd_cost,
    input  logic [2:0]        rd_dir,
    output logic              step_valid,
    input  logic              step_ready,
    output logic [XW-1:0]     step_x,
    output logic [YW-1:0]     step_y,
    output logic              step_last,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int CNT_W = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_STEPS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EMIT  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_nextState;
    logic [XW-1:0]     r_curX;
    logic [YW-1:0]     r_curY;
    logic [CNT_W-1:0]  r_cnt;
    logic [COST_W-1:0] r_cost;
    logic [2:0]        r_dir;
    logic [1:0]        r_errCode;

    logic [XW-1:0]     w_nextX;
    logic [YW-1:0]     w_nextY;
    logic              w_oob;
    logic              w_last;
    logic              w_handshake;

    dir_offset #(.GW(GW), .GH(GH), .XW(XW), .YW(YW)) u_dirOffset (
        .i_x   (r_curX),
        .i_y   (r_curY),
        .i_dir (r_dir),
        .o_nx  (w_nextX),
        .o_ny  (w_nextY),
        .o_oob (w_oob)
    );

    assign w_last      = (r_cost == '0);
    assign w_handshake = (r_state == S_EMIT) && step_ready;

    // Next-state decision; abort overrides everything, including a handshake
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (start) w_nextState = S_FETCH;
            S_FETCH: w_nextState = (rd_cost == COST_INF) ? S_ERR : S_EMIT;
            S_EMIT: begin
                if (w_handshake) begin
                    if (w_last)                 w_nextState = S_DONE;
                    else if (r_cnt == CNT_LAST) w_nextState = S_ERR;
                    else if (w_oob)             w_nextState = S_ERR;
                    else                        w_nextState = S_FETCH;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
        if (abort) w_nextState = S_IDLE;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_nextState;
    end

    // Trace datapath: current node, step counter, latched node data, error code
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_curX    <= '0;
            r_curY    <= '0;
            r_cnt     <= '0;
            r_cost    <= '0;
            r_dir     <= '0;
            r_errCode <= ERR_NONE;
        end else if (!abort) begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_curX    <= goal_x;
                        r_curY    <= goal_y;
                        r_cnt     <= '0;
                        r_errCode <= ERR_NONE;
                    end
                end
                S_FETCH: begin
                    r_cost <= rd_cost;
                    r_dir  <= rd_dir;
                    if (rd_cost == COST_INF) r_errCode <= ERR_UNREACH;
                end
                S_EMIT: begin
                    if (w_handshake && !w_last) begin
                        if (r_cnt == CNT_LAST) begin
                            r_errCode <= ERR_LOOP;
                        end else if (w_oob) begin
                            r_errCode <= ERR_BOUNDS;
                        end else begin
                            r_curX <= w_nextX;
                            r_curY <= w_nextY;
                            r_cnt  <= r_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_x       = r_curX;
    assign rd_y       = r_curY;
    assign step_valid = (r_state == S_EMIT);
    assign step_x     = r_curX;
    assign step_y     = r_curY;
    assign step_last  = step_valid && w_last;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign err        = (r_state == S_ERR);
    assign err_code   = r_errCode;

endmodule

// File: tb/tb_path_tracer.sv
// Bench for path_tracer: a behavioural node grid answers reads, the stimulus
// process queues expected steps and terminations, and a monitor compares.
module tb_path_tracer;

    localparam int GW   = 16;
    localparam int GH   = 16;
    localparam int XW   = 4;
    localparam int YW   = 4;
    localparam int MAXS = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [XW-1:0] goal_x;
    logic [YW-1:0] goal_y;
    logic [XW-1:0] rd_x;
    logic [YW-1:0] rd_y;
    logic [11:0]   rd_cost;
    logic [2:0]    rd_dir;
    logic          step_valid;
    logic          step_ready;
    logic [XW-1:0] step_x;
    logic [YW-1:0] step_y;
    logic          step_last;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;

    logic [11:0] costMem [0:255];
    logic [2:0]  dirMem  [0:255];

    typedef struct packed { logic [3:0] x; logic [3:0] y; logic last; } stepT;
    typedef struct packed { logic isErr; logic [1:0] code; } endT;
    stepT stepQ[$];
    endT  endQ[$];

    int errors = 0;
    int checks = 0;

    path_tracer #(.GW(GW), .GH(GH), .XW(XW), .YW(YW), .MAX_STEPS(MAXS)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .goal_x     (goal_x),
        .goal_y     (goal_y),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_cost    (rd_cost),
        .rd_dir     (rd_dir),
        .step_valid (step_valid),
        .step_ready (step_ready),
        .step_x     (step_x),
        .step_y     (step_y),
        .step_last  (step_last),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Node array answers reads combinationally
    assign rd_cost = costMem[{rd_y, rd_x}];
    assign rd_dir  = dirMem[{rd_y, rd_x}];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic setNode(input int x, input int y, input int cost, input int dir);
        costMem[y*16 + x] = 12'(cost);
        dirMem[y*16 + x]  = 3'(dir);
    endtask

    task automatic pushStep(input int x, input int y, input int last);
        stepT s;
        s.x = 4'(x); s.y = 4'(y); s.last = 1'(last);
        stepQ.push_back(s);
    endtask

    task automatic pushEnd(input int isErr, input int code);
        endT e;
        e.isErr = 1'(isErr); e.code = 2'(code);
        endQ.push_back(e);
    endtask

    // Pulse start for one cycle; returns just after the edge that accepts it
    task automatic applyStimulus(input int gx, input int gy);
        @(posedge clk); #1;
        goal_x = 4'(gx);
        goal_y = 4'(gy);
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("idle timeout", int'(busy), 0);
    endtask

    // Monitor: compares accepted steps and termination pulses to the queues
    always @(negedge clk) begin
        if (!rst) begin
            if (step_valid && step_ready && !abort) begin
                if (stepQ.size() == 0) begin
                    checkOutput("unexpected step", 1, 0);
                end else begin
                    stepT e;
                    e = stepQ.pop_front();
                    checkOutput("step_x", int'(step_x), int'(e.x));
                    checkOutput("step_y", int'(step_y), int'(e.y));
                    checkOutput("step_last", int'(step_last), int'(e.last));
                end
            end
            if (done || err) begin
                if (endQ.size() == 0) begin
                    checkOutput("unexpected done/err", 1, 0);
                end else begin
                    endT e;
                    e = endQ.pop_front();
                    checkOutput("end is err", int'(err), int'(e.isErr));
                    checkOutput("end done", int'(done), int'(!e.isErr));
                    checkOutput("end err_code", int'(err_code), int'(e.code));
                end
            end
        end
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        goal_x     = '0;
        goal_y     = '0;
        step_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            costMem[i] = 12'd100;
            dirMem[i]  = 3'd0;
        end

        // Reset state
        #2;
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset step_valid", int'(step_valid), 0);
        checkOutput("reset step_last", int'(step_last), 0);
        checkOutput("reset done", int'(done), 0);
        checkOutput("reset err", int'(err), 0);
        checkOutput("reset err_code", int'(err_code), 0);
        checkOutput("reset rd_x", int'(rd_x), 0);
        checkOutput("reset rd_y", int'(rd_y), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single-node trace: goal is already the source
        $display("[TB] single-node trace");
        setNode(3, 3, 0, 0);
        pushStep(3, 3, 1);
        pushEnd(0, 0);
        applyStimulus(3, 3);
        checkOutput("fetch busy", int'(busy), 1);
        checkOutput("fetch step_valid", int'(step_valid), 0);
        checkOutput("fetch rd_x", int'(rd_x), 3);
        checkOutput("fetch rd_y", int'(rd_y), 3);
        @(posedge clk); #1;
        checkOutput("first step_valid latency", int'(step_valid), 1);
        waitIdle();
        checkOutput("single err_code", int'(err_code), 0);

        // Multi-step trace W, W, N to a source at (3,4)
        $display("[TB] four-step trace");
        setNode(5, 5, 3, 6);
        setNode(4, 5, 2, 6);
        setNode(3, 5, 1, 0);
        setNode(3, 4, 0, 0);
        pushStep(5, 5, 0);
        pushStep(4, 5, 0);
        pushStep(3, 5, 0);
        pushStep(3, 4, 1);
        pushEnd(0, 0);
        applyStimulus(5, 5);
        repeat (7) @(posedge clk);
        #1;
        checkOutput("done not early", int'(done), 0);
        @(posedge clk); #1;
        checkOutput("done at two cycles per step", int'(done), 1);
        waitIdle();

        // Unreachable goal
        $display("[TB] unreachable goal");
        setNode(7, 7, 12'hFFF, 0);
        pushEnd(1, 1);
        applyStimulus(7, 7);
        @(posedge clk); #1;
        checkOutput("unreach err pulse", int'(err), 1);
        checkOutput("unreach err_code", int'(err_code), 1);
        checkOutput("unreach step_valid", int'(step_valid), 0);
        waitIdle();

        // Step off the north edge
        $display("[TB] bounds trace");
        setNode(0, 0, 5, 0);
        pushStep(0, 0, 0);
        pushEnd(1, 3);
        applyStimulus(0, 0);
        waitIdle();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bounds err_code held", int'(err_code), 3);

        // Two nodes pointing at each other exhaust the step budget
        $display("[TB] loop trace");
        setNode(2, 2, 5, 2);
        setNode(3, 2, 5, 6);
        pushStep(2, 2, 0);
        pushStep(3, 2, 0);
        pushStep(2, 2, 0);
        pushStep(3, 2, 0);
        pushEnd(1, 2);
        applyStimulus(2, 2);
        waitIdle();
        checkOutput("loop err_code", int'(err_code), 2);

        // Abort on a same-cycle handshake: step dropped, no pulse
        $display("[TB] abort during emit");
        setNode(9, 9, 5, 2);
        applyStimulus(9, 9);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checkOutput("abort busy", int'(busy), 0);
        checkOutput("abort step_valid", int'(step_valid), 0);
        checkOutput("abort err_code cleared", int'(err_code), 0);
        repeat (2) @(posedge clk);

        // Stalled output stays stable, then reset mid-emit clears everything
        $display("[TB] stall then reset");
        step_ready = 1'b0;
        applyStimulus(3, 3);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall step_valid", int'(step_valid), 1);
            checkOutput("stall step_x", int'(step_x), 3);
            checkOutput("stall step_y", int'(step_y), 3);
            checkOutput("stall step_last", int'(step_last), 1);
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        checkOutput("async rst step_valid", int'(step_valid), 0);
        checkOutput("async rst step_last", int'(step_last), 0);
        checkOutput("async rst busy", int'(busy), 0);
        checkOutput("async rst done", int'(done), 0);
        checkOutput("async rst err", int'(err), 0);
        checkOutput("async rst rd_x", int'(rd_x), 0);
        @(posedge clk); #1;
        rst        = 1'b0;
        step_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("no done after reset", int'(done), 0);
        checkOutput("pending steps", stepQ.size(), 0);
        checkOutput("pending ends", endQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
